// File: rtl/snoop_ingest.sv
// Packet snooper ingest: steers strobed words into a two-buffer RAM,
// offers complete packets in arrival order and counts dropped packets.
module snoop_ingest #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           data,
  input  logic                  strobe,
  input  logic                  last,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   wr_addr,
  output logic [31:0]           wr_data,
  output logic                  pkt_valid,
  output logic                  pkt_sel,
  output logic [ADDR_WIDTH:0]   pkt_len,
  input  logic                  pkt_done,
  output logic [15:0]           drop_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DROP
  } state_t;

  localparam logic [ADDR_WIDTH:0] CAP =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_wr_sel;
  logic                  r_rd_sel;
  logic [1:0]            r_full;
  logic [1:0]            w_full_nxt;
  logic [ADDR_WIDTH:0]   r_len0;
  logic [ADDR_WIDTH:0]   r_len1;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH:0]   w_cnt_nxt;
  logic [ADDR_WIDTH:0]   w_len_new;
  logic [15:0]           r_drop;
  logic                  r_wr_en;
  logic [ADDR_WIDTH:0]   r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  w_acc;
  logic                  w_cmp;
  logic                  w_drop;
  logic                  w_rel;
  logic                  w_free;
  logic [ADDR_WIDTH-1:0] w_idx;

  // Free check uses the registered full bit only.
  assign w_free    = ~r_full[r_wr_sel];
  assign w_rel     = pkt_done & r_full[r_rd_sel];
  assign w_len_new = r_cnt + ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc       = 1'b0;
    w_cmp       = 1'b0;
    w_drop      = 1'b0;
    w_idx       = '0;
    unique case (r_state)
      S_IDLE: begin
        if (strobe) begin
          if (w_free) begin
            w_acc = 1'b1;
            if (last) begin
              w_cmp     = 1'b1;
              w_cnt_nxt = '0;
            end else begin
              w_state_nxt = S_FILL;
              w_cnt_nxt   = ONE;
            end
          end else begin
            w_drop      = 1'b1;
            w_state_nxt = last ? S_IDLE : S_DROP;
          end
        end
      end
      S_FILL: begin
        if (strobe) begin
          if (r_cnt != CAP) begin
            w_acc = 1'b1;
            w_idx = r_cnt[ADDR_WIDTH-1:0];
            if (last) begin
              w_cmp       = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = w_len_new;
            end
          end else begin
            w_drop      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = last ? S_IDLE : S_DROP;
          end
        end
      end
      S_DROP: begin
        if (strobe && last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Completion and release always hit different buffers.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rel) begin
      w_full_nxt[r_rd_sel] = 1'b0;
    end
    if (w_cmp) begin
      w_full_nxt[r_wr_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_full   <= 2'b00;
      r_cnt    <= '0;
      r_len0   <= '0;
      r_len1   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= w_full_nxt;
      if (w_cmp) begin
        r_wr_sel <= ~r_wr_sel;
        if (r_wr_sel) begin
          r_len1 <= w_len_new;
        end else begin
          r_len0 <= w_len_new;
        end
      end
      if (w_rel) begin
        r_rd_sel <= ~r_rd_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_acc;
      if (w_acc) begin
        r_wr_addr <= {r_wr_sel, w_idx};
        r_wr_data <= data;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign pkt_valid  = r_full[r_rd_sel];
  assign pkt_sel    = r_rd_sel;
  assign pkt_len    = r_rd_sel ? r_len1 : r_len0;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_snoop_ingest.sv
// Bench for snoop_ingest: default and ADDR_WIDTH=2 instances share
// stimulus; a packet-level model is compared every cycle.
module tb_snoop_ingest;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data = '0;
  logic        strobe = 1'b0;
  logic        last = 1'b0;
  logic        pkt_done = 1'b0;

  logic        o9_wr_en;
  logic [9:0]  o9_wr_addr;
  logic [31:0] o9_wr_data;
  logic        o9_valid;
  logic        o9_sel;
  logic [9:0]  o9_len;
  logic [15:0] o9_drop;

  logic        o2_wr_en;
  logic [2:0]  o2_wr_addr;
  logic [31:0] o2_wr_data;
  logic        o2_valid;
  logic        o2_sel;
  logic [2:0]  o2_len;
  logic [15:0] o2_drop;

  int n_chk = 0;
  int n_fail = 0;
  bit go = 1'b0;

  always #5 clk = ~clk;

  snoop_ingest u_d9 (
    .clk(clk), .rst(rst), .data(data), .strobe(strobe),
    .last(last), .wr_en(o9_wr_en), .wr_addr(o9_wr_addr),
    .wr_data(o9_wr_data), .pkt_valid(o9_valid),
    .pkt_sel(o9_sel), .pkt_len(o9_len),
    .pkt_done(pkt_done), .drop_count(o9_drop)
  );

  snoop_ingest #(.ADDR_WIDTH(2)) u_d2 (
    .clk(clk), .rst(rst), .data(data), .strobe(strobe),
    .last(last), .wr_en(o2_wr_en), .wr_addr(o2_wr_addr),
    .wr_data(o2_wr_data), .pkt_valid(o2_valid),
    .pkt_sel(o2_sel), .pkt_len(o2_len),
    .pkt_done(pkt_done), .drop_count(o2_drop)
  );

  // Model: per instance, packet-level bookkeeping.
  // mode 0 = waiting for first word, 1 = collecting, 2 = discarding.
  int          m_mode[2];
  int          m_cnt[2];
  int          m_ncomp[2];
  int          m_nrel[2];
  int          m_occ[2];
  int          m_len[2][2];
  int          m_drop[2];
  bit          m_wen[2];
  int          m_addr[2];
  logic [31:0] m_data[2];

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k]   = 0;
      m_cnt[k]    = 0;
      m_ncomp[k]  = 0;
      m_nrel[k]   = 0;
      m_occ[k]    = 0;
      m_len[k][0] = 0;
      m_len[k][1] = 0;
      m_drop[k]   = 0;
      m_wen[k]    = 1'b0;
      m_addr[k]   = 0;
      m_data[k]   = '0;
    end
  endtask

  task automatic model_step(input int k, input bit s, input bit l,
                            input logic [31:0] d, input bit dn);
    int  cap;
    int  wsel;
    bit  fullw;
    bit  rel;
    bit  comp;
    int  clen;
    cap   = (k == 0) ? 512 : 4;
    wsel  = m_ncomp[k] % 2;
    fullw = (m_occ[k] == 2);
    rel   = dn && (m_occ[k] > 0);
    comp  = 1'b0;
    clen  = 0;
    m_wen[k] = 1'b0;
    if (s) begin
      if (m_mode[k] == 0) begin
        if (!fullw) begin
          m_wen[k]  = 1'b1;
          m_addr[k] = wsel * cap;
          m_data[k] = d;
          if (l) begin
            comp = 1'b1;
            clen = 1;
          end else begin
            m_mode[k] = 1;
            m_cnt[k]  = 1;
          end
        end else begin
          if (m_drop[k] < 65535) m_drop[k]++;
          m_mode[k] = l ? 0 : 2;
        end
      end else if (m_mode[k] == 1) begin
        if (m_cnt[k] < cap) begin
          m_wen[k]  = 1'b1;
          m_addr[k] = wsel * cap + m_cnt[k];
          m_data[k] = d;
          m_cnt[k]++;
          if (l) begin
            comp = 1'b1;
            clen = m_cnt[k];
            m_mode[k] = 0;
          end
        end else begin
          if (m_drop[k] < 65535) m_drop[k]++;
          m_mode[k] = l ? 0 : 2;
        end
      end else begin
        if (l) m_mode[k] = 0;
      end
    end
    if (rel) begin
      m_occ[k]--;
      m_nrel[k]++;
    end
    if (comp) begin
      m_len[k][wsel] = clen;
      m_occ[k]++;
      m_ncomp[k]++;
    end
  endtask

  task automatic chk_out(input int k, input bit wen, input int addr,
                         input logic [31:0] wd, input bit v,
                         input bit sel, input int len,
                         input int drop);
    int rs;
    rs = m_nrel[k] % 2;
    check($sformatf("d%0d.wr_en", k), wen, m_wen[k]);
    if (m_wen[k]) begin
      check($sformatf("d%0d.wr_addr", k), addr, m_addr[k]);
      check($sformatf("d%0d.wr_data", k), wd, m_data[k]);
    end
    check($sformatf("d%0d.pkt_valid", k), v, m_occ[k] > 0);
    check($sformatf("d%0d.pkt_sel", k), sel, rs);
    check($sformatf("d%0d.pkt_len", k), len, m_len[k][rs]);
    check($sformatf("d%0d.drop", k), drop, m_drop[k]);
  endtask

  always @(negedge clk) begin
    if (go) begin
      chk_out(0, o9_wr_en, int'(o9_wr_addr), o9_wr_data, o9_valid,
              o9_sel, int'(o9_len), int'(o9_drop));
      chk_out(1, o2_wr_en, int'(o2_wr_addr), o2_wr_data, o2_valid,
              o2_sel, int'(o2_len), int'(o2_drop));
    end
  end

  // One clock: apply inputs, advance the model, land at negedge+1.
  task automatic cyc(input bit s, input bit l, input logic [31:0] d,
                     input bit dn);
    strobe   = s;
    last     = l;
    data     = d;
    pkt_done = dn;
    model_step(0, s, l, d, dn);
    model_step(1, s, l, d, dn);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    strobe   = 1'b0;
    last     = 1'b0;
    pkt_done = 1'b0;
    rst      = 1'b0;
    model_reset();
    #1;
    check("rst.wr_en", o9_wr_en, 0);
    check("rst.wr_addr", o9_wr_addr, 0);
    check("rst.wr_data", o9_wr_data, 0);
    check("rst.pkt_valid", o9_valid, 0);
    check("rst.pkt_len", o9_len, 0);
    check("rst.drop", o9_drop, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    go = 1'b1;
    @(negedge clk);
    #1;
    do_reset();

    // single packet
    cyc(1, 0, 32'hA0, 0);
    check("sp.wen0", o9_wr_en, 1);
    check("sp.addr0", o9_wr_addr, 0);
    check("sp.data0", o9_wr_data, 32'hA0);
    cyc(1, 0, 32'hA1, 0);
    check("sp.addr1", o9_wr_addr, 1);
    cyc(1, 1, 32'hA2, 0);
    check("sp.addr2", o9_wr_addr, 2);
    check("sp.valid", o9_valid, 1);
    check("sp.sel", o9_sel, 0);
    check("sp.len", o9_len, 3);

    // ping-pong
    do_reset();
    cyc(1, 0, 32'hB0, 0);
    cyc(1, 1, 32'hB1, 0);
    cyc(1, 0, 32'hC0, 0);
    cyc(1, 1, 32'hC1, 0);
    cyc(0, 0, 32'h0, 0);
    check("pp.valid0", o9_valid, 1);
    check("pp.sel0", o9_sel, 0);
    check("pp.len0", o9_len, 2);
    cyc(0, 0, 32'h0, 1);
    check("pp.valid1", o9_valid, 1);
    check("pp.sel1", o9_sel, 1);
    check("pp.len1", o9_len, 2);
    cyc(0, 0, 32'h0, 1);
    check("pp.empty", o9_valid, 0);

    // both full, third packet dropped despite same-cycle release
    do_reset();
    cyc(1, 0, 32'hB0, 0);
    cyc(1, 1, 32'hB1, 0);
    cyc(1, 0, 32'hC0, 0);
    cyc(1, 1, 32'hC1, 0);
    cyc(1, 0, 32'hD0, 1);
    check("bf.wen", o9_wr_en, 0);
    check("bf.drop", o9_drop, 1);
    check("bf.sel", o9_sel, 1);
    cyc(1, 0, 32'hD1, 0);
    cyc(1, 0, 32'hD2, 0);
    cyc(1, 1, 32'hD3, 0);
    check("bf.wen3", o9_wr_en, 0);
    check("bf.drop3", o9_drop, 1);
    cyc(1, 1, 32'hE0, 0);
    check("bf.next_wen", o9_wr_en, 1);
    check("bf.next_addr", o9_wr_addr, 0);

    // overflow on the small instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, i == 4, 32'h50 + i, 0);
      check($sformatf("ov.wen%0d", i), o2_wr_en, i < 4);
    end
    check("ov.drop", o2_drop, 1);
    check("ov.valid", o2_valid, 0);
    check("ov.d9len", o9_len, 5);
    cyc(1, 1, 32'h60, 0);
    check("ov.addr", o2_wr_addr, 0);
    check("ov.valid2", o2_valid, 1);
    check("ov.sel2", o2_sel, 0);
    check("ov.len2", o2_len, 1);

    // gapped strobe
    do_reset();
    cyc(1, 0, 32'hF0, 0);
    cyc(0, 0, 32'hFFFF_FFFF, 0);
    check("gap.wen0", o9_wr_en, 0);
    cyc(1, 0, 32'hF1, 0);
    check("gap.addr1", o9_wr_addr, 1);
    check("gap.data1", o9_wr_data, 32'hF1);
    cyc(0, 1, 32'h1234_5678, 0);
    check("gap.wen1", o9_wr_en, 0);
    cyc(1, 1, 32'hF2, 0);
    check("gap.addr2", o9_wr_addr, 2);
    check("gap.len", o9_len, 3);

    // reset mid-packet
    do_reset();
    cyc(1, 0, 32'h70, 0);
    cyc(1, 0, 32'h71, 0);
    do_reset();
    cyc(1, 1, 32'h80, 0);
    check("mr.valid", o9_valid, 1);
    check("mr.sel", o9_sel, 0);
    check("mr.len", o9_len, 1);
    check("mr.addr", o9_wr_addr, 0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 99) < 65,
            $urandom_range(0, 99) < 30,
            $urandom,
            $urandom_range(0, 99) < 25);
      end
    end

    go = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snoop_ingest.md
SNOOP_INGEST -- requirements
Module: snoop_ingest

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, giving log2 of words per packet buffer.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port data  input  32  packet word from the upstream word source.
REQ-005 SHALL have port strobe  input  1  data is a valid word this cycle.
REQ-006 SHALL have port last  input  1  qualified by strobe; word is the final word of its packet.
REQ-007 SHALL have port wr_en  output  1  write enable to the two-buffer packet RAM.
REQ-008 SHALL have port wr_addr  output  ADDR_WIDTH+1  RAM address; MSB is buffer select, LSBs are word index.
REQ-009 SHALL have port wr_data  output  32  RAM write data.
REQ-010 SHALL have port pkt_valid  output  1  buffer rd_sel holds a complete packet.
REQ-011 SHALL have port pkt_sel  output  1  index of the buffer offered to the filter.
REQ-012 SHALL have port pkt_len  output  ADDR_WIDTH+1  word count of the offered packet.
REQ-013 SHALL have port pkt_done  input  1  one-cycle pulse; the filter has finished with buffer pkt_sel.
REQ-014 SHALL have port drop_count  output  16  number of dropped packets, saturating.

Function
REQ-015 SHALL keep state wr_sel, rd_sel, full[1:0], len0, len1, word counter cnt (ADDR_WIDTH+1 bits) and FSM {IDLE, FILL, DROP}.
REQ-016 SHALL ignore data and last on any cycle with strobe=0.
REQ-017 In IDLE with strobe=1 and full[wr_sel]=0: SHALL write the word at index 0 and set cnt=1; if last=0 go to FILL, else complete the packet (REQ-020).
REQ-018 In IDLE with strobe=1 and full[wr_sel]=1: SHALL issue no write, increment drop_count, and go to DROP; if last=1, stay in IDLE instead.
REQ-019 In FILL with strobe=1 and cnt<2^ADDR_WIDTH: SHALL write the word at index cnt and increment cnt.
REQ-020 On a strobed last word accepted in IDLE or FILL: SHALL set full[wr_sel]=1, latch len[wr_sel]=cnt+1, toggle wr_sel, clear cnt, and go to IDLE.
REQ-021 In FILL with strobe=1 and cnt==2^ADDR_WIDTH (overflow): SHALL not write, leave full[wr_sel]=0, increment drop_count, and go to DROP; if that word has last=1, go to IDLE.
REQ-022 In DROP: SHALL discard words and return to IDLE on the cycle after a strobed last word.
REQ-023 wr_en, wr_addr and wr_data SHALL be registered, asserting exactly one cycle after the accepted strobe; wr_addr MSB = wr_sel at acceptance.
REQ-024 pkt_valid SHALL equal full[rd_sel], pkt_sel SHALL equal rd_sel, and pkt_len SHALL equal len[rd_sel].
REQ-025 On pkt_done with pkt_valid=1: SHALL clear full[rd_sel] and toggle rd_sel on that edge; pkt_done with pkt_valid=0 SHALL be ignored.
REQ-026 The free check in REQ-017/018 SHALL use the registered full bit, so a release on the same cycle as a first word does not save that packet.
REQ-027 A completion (REQ-020) and a release (REQ-025) in the same cycle SHALL both take effect; they always target different buffers.
REQ-028 drop_count SHALL hold at 16'hFFFF once reached.
REQ-029 Packets SHALL be offered in arrival order; neither buffer is overwritten while full.

Reset
REQ-030 While rst=0: SHALL set state IDLE, wr_sel=0, rd_sel=0, full=2'b00, cnt=0, len0=len1=0, drop_count=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-031 Asserting rst mid-packet SHALL discard the partial packet and any full buffers; after release, the next strobed word is treated as a first word.

Verification
REQ-032 Single packet: words A0..A2 strobed, last on A2 -> writes to addresses 0,1,2 one cycle after each strobe; pkt_valid=1, pkt_sel=0, pkt_len=3.
REQ-033 Ping-pong: two 2-word packets, no pkt_done -> buffer 0 len 2 offered; pkt_done -> pkt_sel=1, pkt_len=2, pkt_valid=1; second pkt_done -> pkt_valid=0.
REQ-034 Both buffers full, third 4-word packet arrives -> no wr_en, drop_count=1; a pkt_done on the third packet's first word does not rescue it.
REQ-035 ADDR_WIDTH=2, 5-word packet -> 4 writes, 5th word dropped, drop_count=1, full stays 00; next 1-word packet lands in buffer 0 with len 1.
REQ-036 Gapped strobe (strobe low between words, data toggling) -> only strobed words written, at contiguous addresses.
REQ-037 rst low for one cycle after the 2nd word of a packet -> all outputs at reset values; the following 1-word packet gives pkt_sel=0, pkt_len=1.
